ahb3lite_led_timer: RTL and testbench
=====================================

Name: ahb3lite_led_timer

Overview:
- AHB3-Lite slave peripheral on an interconnect slave port, the consumer of slv_h* signals, at base 0x4000_0000.
- Holds the board LED output register with set and clear aliases.
- Holds a 32-bit reload down-counter. On each expiry the counter sets a sticky flag, can raise an IRQ, and XOR-toggles a programmable LED mask.
- Firmware blinks LEDs without busy-wait loops.

Parameters:
- g_led_num, 8: number of LED outputs (1..32).
- g_haddr_width, 32: HADDR width. Only bits [4:2] are decoded.
- g_hdata_width, 32: data width. Fixed at 32; any other value is a synthesis error.

Ports:
- hclk_i, input, 1: bus clock. Single clock domain.
- hreset_n_i, input, 1: asynchronous active-low reset.
- hsel_i, input, 1: slave select from the interconnect.
- haddr_i, input, g_haddr_width: address.
- hwdata_i, input, 32: write data (data phase).
- hrdata_o, output, 32: read data (data phase).
- hwrite_i, input, 1: 1 = write.
- hsize_i, input, 3: transfer size.
- hburst_i, input, 3: ignored.
- hprot_i, input, 4: ignored.
- htrans_i, input, 2: transfer type.
- hready_i, input, 1: combined HREADY.
- hreadyout_o, output, 1: slave ready.
- hresp_o, output, 1: 0 = OKAY, 1 = ERROR.
- led_o, output, g_led_num: LED drive, equal to LED_OUT.
- irq_o, output, 1: level interrupt, equal to STAT.EXP & CTRL.IE.

Behaviour:
- Reset values: all registers 0, hrdata_o = 0, hreadyout_o = 1, hresp_o = 0, led_o = 0, irq_o = 0.

Address phase:
- A transfer is accepted when hsel_i & hready_i & htrans_i[1] is true.
- On acceptance, register haddr[4:2], hwrite and a size_ok flag (hsize_i == 3'b010) into the data-phase controls.
- IDLE and BUSY transfers, or an unselected slave, produce an OKAY zero-wait data phase with no side effects.

Data phase, size_ok transfer:
- Zero wait states: hreadyout_o = 1, hresp_o = 0.
- Writes commit on the clock edge that ends the data phase, using hwdata_i.
- Reads drive hrdata_o combinationally from the registered offset.
- A read issued right after a write to the same register returns the newly written value.

Data phase, non-word transfer (size_ok = 0):
- Two-cycle ERROR response.
  - Cycle 1: hreadyout_o = 0, hresp_o = 1.
  - Cycle 2: hreadyout_o = 1, hresp_o = 1.
- No register changes.
- Response FSM states: IDLE, ERR1, ERR2. ERR2 returns to IDLE, or re-enters ERR1 if the next accepted transfer is also non-word.

Register map (offsets):
- 0x00 LED_OUT: RW, bits [g_led_num-1:0]. Upper bits read 0.
- 0x04 LED_SET: WO. LED_OUT |= wdata. Reads 0.
- 0x08 LED_CLR: WO. LED_OUT &= ~wdata. Reads 0.
- 0x0C CTRL: RW. Bit0 = EN, bit1 = IE.
- 0x10 LOAD: RW, 32 bits. A write also loads VAL with wdata on the same edge.
- 0x14 VAL: RO. Writes are ignored.
- 0x18 STAT: bit0 = EXP, write-1-to-clear.
- 0x1C TGL_MASK: RW, g_led_num bits.

Counter:
- While EN = 1, each cycle: if VAL == 0, then VAL <= LOAD and EXP <= 1 and LED_OUT ^= TGL_MASK; otherwise VAL <= VAL - 1.
- Period is LOAD + 1 cycles. LOAD = 0 expires every cycle.
- EN = 0 freezes VAL. Clearing EN does not change VAL or EXP.
- No underflow past 0: the reload happens instead.

Simultaneous events:
- LOAD write and expiry in the same cycle: the written value wins for VAL. EXP is still set.
- STAT W1C and expiry in the same cycle: the set wins, EXP = 1.
- LED_OUT write and toggle in the same cycle: the write value wins.
- LED_SET/LED_CLR and toggle in the same cycle: the toggle is applied first, then the set/clear mask.
- CTRL write with EN = 1: the counter starts decrementing on the following cycle.

Reset:
- Asserting hreset_n_i mid-transfer or mid-ERROR immediately returns every register and output to its reset value.
- The FSM returns to IDLE.

Test Plan:
- Reset, then read every offset → all return 0x0000_0000. led_o = 0, irq_o = 0, hreadyout_o = 1.
- Write LED_OUT = 0xA5, then LED_SET = 0x0A, then LED_CLR = 0x81 → reads return 0xA5, then 0xAF, then 0x2E. led_o tracks each value one edge after its data phase.
- Write LOAD = 3, TGL_MASK = 0x01, CTRL = 0x3 → EXP sets and LED0 toggles every 4 cycles. irq_o = 1 until a STAT write of 0x1. A W1C on the expiry cycle leaves EXP = 1.
- Halfword write (hsize = 1) to LED_OUT with 0xFF → data phase is hreadyout 0/1 with hresp 1/1. LED_OUT is unchanged. The next word read is OKAY with zero wait.
- Back-to-back pipelined write LOAD = 0x10 then read VAL with EN = 0 → the read returns 0x0000_0010. With EN = 1, a LOAD write on the reload cycle leaves VAL = the written value.
- Assert hreset_n_i during ERR1 with LED_OUT = 0xFF and EN = 1 → same-cycle async clear: led_o = 0, hresp_o = 0, hreadyout_o = 1, VAL = 0.

Source files
------------

// File: rtl/ahb3lite_led_timer.sv
// ahb3lite_led_timer: AHB3-Lite slave holding the board LED register (with
// set/clear aliases) and a 32-bit reload down-counter. Each expiry sets a
// sticky EXP flag, may raise irq_o, and XOR-toggles a programmable LED mask.
//
// Ports:
//   hclk_i, hreset_n_i          bus clock, async active-low reset
//   hsel_i, haddr_i, htrans_i,
//   hwrite_i, hsize_i,
//   hburst_i, hprot_i, hready_i AHB address-phase inputs (hburst/hprot ignored)
//   hwdata_i                    write data (data phase)
//   hrdata_o, hreadyout_o,
//   hresp_o                     AHB data-phase response
//   led_o                       LED drive (LED_OUT)
//   irq_o                       level interrupt, STAT.EXP & CTRL.IE
module ahb3lite_led_timer #(
  parameter int unsigned g_led_num     = 8,
  parameter int unsigned g_haddr_width = 32,
  parameter int unsigned g_hdata_width = 32
) (
  input  logic                     hclk_i,
  input  logic                     hreset_n_i,
  input  logic                     hsel_i,
  input  logic [g_haddr_width-1:0] haddr_i,
  input  logic [g_hdata_width-1:0] hwdata_i,
  output logic [g_hdata_width-1:0] hrdata_o,
  input  logic                     hwrite_i,
  input  logic [2:0]               hsize_i,
  input  logic [2:0]               hburst_i,
  input  logic [3:0]               hprot_i,
  input  logic [1:0]               htrans_i,
  input  logic                     hready_i,
  output logic                     hreadyout_o,
  output logic                     hresp_o,
  output logic [g_led_num-1:0]     led_o,
  output logic                     irq_o
);

  if (g_hdata_width != 32) begin : g_bad_hdata_width
    $error("ahb3lite_led_timer: g_hdata_width must be 32");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} resp_state_t;

  resp_state_t state, state_next;

  logic        accept, size_ok, wr_en;
  logic        dp_valid, dp_write;
  logic [2:0]  dp_addr;

  logic [g_led_num-1:0] led_out, led_out_next;
  logic [g_led_num-1:0] tgl_mask, tgl_mask_next;
  logic                 en, en_next, ie, ie_next;
  logic                 exp_flag, exp_next;
  logic [31:0]          load, load_next, val, val_next;
  logic                 tick;
  logic [31:0]          rd_data;

  logic unused_inputs;
  assign unused_inputs = ^{hburst_i, hprot_i, htrans_i[0],
                           haddr_i[g_haddr_width-1:5], haddr_i[1:0]};

  assign accept  = hsel_i & hready_i & htrans_i[1];
  assign size_ok = (hsize_i == 3'b010);

  // Data-phase controls only advance when the bus is ready; non-word
  // transfers never arm dp_valid, so they cannot touch registers.
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (hready_i) begin
      dp_valid <= accept & size_ok;
      dp_write <= hwrite_i;
      dp_addr  <= haddr_i[4:2];
    end
  end

  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) state <= ST_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next  = state;
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    case (state)
      ST_IDLE: if (accept && !size_ok) state_next = ST_ERR1;
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
        state_next  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_o    = 1'b1;
        state_next = (accept && !size_ok) ? ST_ERR1 : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wr_en = dp_valid & dp_write & hready_i;
  assign tick  = en & (val == '0);

  // Priority: register writes override counter effects, except LED_SET/CLR
  // which apply on top of the toggled value and STAT W1C which loses to a set.
  always_comb begin
    led_out_next  = tick ? (led_out ^ tgl_mask) : led_out;
    tgl_mask_next = tgl_mask;
    en_next       = en;
    ie_next       = ie;
    load_next     = load;
    val_next      = val;
    exp_next      = exp_flag;
    if (en) val_next = (val == '0) ? load : val - 32'd1;
    if (wr_en) begin
      case (dp_addr)
        3'd0: led_out_next = hwdata_i[g_led_num-1:0];
        3'd1: led_out_next = led_out_next | hwdata_i[g_led_num-1:0];
        3'd2: led_out_next = led_out_next & ~hwdata_i[g_led_num-1:0];
        3'd3: begin
          en_next = hwdata_i[0];
          ie_next = hwdata_i[1];
        end
        3'd4: begin
          load_next = hwdata_i;
          val_next  = hwdata_i;
        end
        3'd6: if (hwdata_i[0]) exp_next = 1'b0;
        3'd7: tgl_mask_next = hwdata_i[g_led_num-1:0];
        default: ;
      endcase
    end
    if (tick) exp_next = 1'b1;
  end

  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      led_out  <= '0;
      tgl_mask <= '0;
      en       <= 1'b0;
      ie       <= 1'b0;
      load     <= '0;
      val      <= '0;
      exp_flag <= 1'b0;
    end else begin
      led_out  <= led_out_next;
      tgl_mask <= tgl_mask_next;
      en       <= en_next;
      ie       <= ie_next;
      load     <= load_next;
      val      <= val_next;
      exp_flag <= exp_next;
    end
  end

  always_comb begin
    rd_data = '0;
    case (dp_addr)
      3'd0: rd_data[g_led_num-1:0] = led_out;
      3'd3: rd_data[1:0]           = {ie, en};
      3'd4: rd_data                = load;
      3'd5: rd_data                = val;
      3'd6: rd_data[0]             = exp_flag;
      3'd7: rd_data[g_led_num-1:0] = tgl_mask;
      default: ;
    endcase
  end

  assign hrdata_o = (dp_valid && !dp_write) ? rd_data : '0;
  assign led_o    = led_out;
  assign irq_o    = exp_flag & ie;

endmodule

// File: tb/tb_ahb3lite_led_timer.sv
module tb_ahb3lite_led_timer;

  logic        clk, hreset_n;
  logic        hsel, hwrite, hready, hreadyout, hresp, irq;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [7:0]  led;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  ahb3lite_led_timer #(
    .g_led_num(8),
    .g_haddr_width(32),
    .g_hdata_width(32)
  ) dut (
    .hclk_i(clk),
    .hreset_n_i(hreset_n),
    .hsel_i(hsel),
    .haddr_i(haddr),
    .hwdata_i(hwdata),
    .hrdata_o(hrdata),
    .hwrite_i(hwrite),
    .hsize_i(hsize),
    .hburst_i(hburst),
    .hprot_i(hprot),
    .htrans_i(htrans),
    .hready_i(hready),
    .hreadyout_o(hreadyout),
    .hresp_o(hresp),
    .led_o(led),
    .irq_o(irq)
  );

  // Single slave on the bus: combined HREADY is this slave's HREADYOUT.
  assign hready = hreadyout;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h4000_0000;
  endtask

  task automatic addr_phase(input logic [4:0] a, input logic wr, input logic [2:0] sz);
    hsel = 1'b1; haddr = 32'h4000_0000 | {27'd0, a}; hwrite = wr; hsize = sz; htrans = 2'b10;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1, 3'b010);
    @(posedge clk); #1;
    idle_bus();
    hwdata = d;
    @(posedge clk); #1;
  endtask

  task automatic read_word(input logic [4:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0, 3'b010);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    d = hrdata;
    @(posedge clk); #1;
  endtask

  vec_t        vecs[20];
  logic [31:0] rd;

  initial begin
    vecs[0]  = '{1'b1, 5'h00, 32'h0000_00A5, 32'h0, 8'hA5};
    vecs[1]  = '{1'b0, 5'h00, 32'h0,         32'h0000_00A5, 8'hA5};
    vecs[2]  = '{1'b1, 5'h04, 32'h0000_000A, 32'h0, 8'hAF};
    vecs[3]  = '{1'b0, 5'h00, 32'h0,         32'h0000_00AF, 8'hAF};
    vecs[4]  = '{1'b1, 5'h08, 32'h0000_0081, 32'h0, 8'h2E};
    vecs[5]  = '{1'b0, 5'h00, 32'h0,         32'h0000_002E, 8'h2E};
    vecs[6]  = '{1'b0, 5'h04, 32'h0,         32'h0, 8'h2E};
    vecs[7]  = '{1'b0, 5'h08, 32'h0,         32'h0, 8'h2E};
    vecs[8]  = '{1'b1, 5'h1C, 32'h0000_01FF, 32'h0, 8'h2E};
    vecs[9]  = '{1'b0, 5'h1C, 32'h0,         32'h0000_00FF, 8'h2E};
    vecs[10] = '{1'b1, 5'h10, 32'h0000_0010, 32'h0, 8'h2E};
    vecs[11] = '{1'b0, 5'h10, 32'h0,         32'h0000_0010, 8'h2E};
    vecs[12] = '{1'b0, 5'h14, 32'h0,         32'h0000_0010, 8'h2E};
    vecs[13] = '{1'b1, 5'h14, 32'h0000_0005, 32'h0, 8'h2E};
    vecs[14] = '{1'b0, 5'h14, 32'h0,         32'h0000_0010, 8'h2E};
    vecs[15] = '{1'b1, 5'h0C, 32'hFFFF_FFFE, 32'h0, 8'h2E};
    vecs[16] = '{1'b0, 5'h0C, 32'h0,         32'h0000_0002, 8'h2E};
    vecs[17] = '{1'b0, 5'h18, 32'h0,         32'h0, 8'h2E};
    vecs[18] = '{1'b1, 5'h1C, 32'h0000_0001, 32'h0, 8'h2E};
    vecs[19] = '{1'b0, 5'h1C, 32'h0,         32'h0000_0001, 8'h2E};

    hreset_n = 1'b0;
    hwdata = '0; hburst = '0; hprot = '0;
    idle_bus();
    #12 hreset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_led", {24'd0, led}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_hreadyout", {31'd0, hreadyout}, 32'h1);
    check("rst_hresp", {31'd0, hresp}, 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    for (int i = 0; i < 8; i++) begin
      read_word(5'(i * 4), rd);
      check($sformatf("rst_read_%0h", i * 4), rd, 32'h0);
    end

    // Register map vectors
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) begin
        write_word(vecs[i].addr, vecs[i].data);
      end else begin
        read_word(vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      end
      check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
    end

    // Timer: LOAD=3, mask=1, EN|IE committed at edge E0; expiries at E0+4k
    write_word(5'h10, 32'd3);
    write_word(5'h0C, 32'h3);
    check("tmr_irq_e0", {31'd0, irq}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("tmr_irq_e3", {31'd0, irq}, 32'h0);
    check("tmr_led_e3", {24'd0, led}, 32'h2E);
    @(posedge clk); #1;
    check("tmr_irq_e4", {31'd0, irq}, 32'h1);
    check("tmr_led_e4", {24'd0, led}, 32'h2F);
    repeat (4) @(posedge clk);
    #1;
    check("tmr_led_e8", {24'd0, led}, 32'h2E);
    check("tmr_irq_e8", {31'd0, irq}, 32'h1);
    write_word(5'h18, 32'h1);               // commits at E0+10
    check("tmr_w1c_irq", {31'd0, irq}, 32'h0);
    write_word(5'h18, 32'h1);               // commits at E0+12, an expiry edge
    check("tmr_w1c_vs_exp", {31'd0, irq}, 32'h1);
    check("tmr_led_e12", {24'd0, led}, 32'h2F);
    write_word(5'h0C, 32'h0);               // commits at E0+14, VAL = 1
    read_word(5'h14, rd);
    check("tmr_val_frozen", rd, 32'h1);
    read_word(5'h18, rd);
    check("tmr_exp_kept", rd, 32'h1);

    // Halfword write: two-cycle ERROR, no change, then zero-wait word read
    addr_phase(5'h00, 1'b1, 3'b001);
    @(posedge clk); #1;
    idle_bus();
    hwdata = 32'hFF;
    check("err1_hreadyout", {31'd0, hreadyout}, 32'h0);
    check("err1_hresp", {31'd0, hresp}, 32'h1);
    @(posedge clk); #1;
    check("err2_hreadyout", {31'd0, hreadyout}, 32'h1);
    check("err2_hresp", {31'd0, hresp}, 32'h1);
    addr_phase(5'h00, 1'b0, 3'b010);
    @(posedge clk); #1;
    idle_bus();
    check("after_err_hreadyout", {31'd0, hreadyout}, 32'h1);
    check("after_err_hresp", {31'd0, hresp}, 32'h0);
    @(negedge clk);
    check("after_err_rdata", hrdata, 32'h2F);
    check("after_err_led", {24'd0, led}, 32'h2F);
    @(posedge clk); #1;

    // Pipelined write LOAD then read VAL (EN = 0)
    addr_phase(5'h10, 1'b1, 3'b010);
    @(posedge clk); #1;
    addr_phase(5'h14, 1'b0, 3'b010);
    hwdata = 32'h10;
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check("pipe_val", hrdata, 32'h10);
    @(posedge clk); #1;

    // LOAD write on the reload edge wins for VAL
    write_word(5'h18, 32'h1);
    read_word(5'h18, rd);
    check("stat_cleared", rd, 32'h0);
    write_word(5'h10, 32'd2);
    write_word(5'h0C, 32'h1);               // EN committed at Ec
    @(posedge clk); #1;
    write_word(5'h10, 32'd7);               // commits at Ec+3, the reload edge
    write_word(5'h0C, 32'h0);               // commits at Ec+5
    read_word(5'h14, rd);
    check("load_vs_reload_val", rd, 32'd5);
    read_word(5'h18, rd);
    check("load_vs_reload_exp", rd, 32'h1);
    check("irq_masked", {31'd0, irq}, 32'h0);

    // Async reset during ERR1
    write_word(5'h00, 32'hFF);
    write_word(5'h10, 32'd100);
    write_word(5'h0C, 32'h1);
    addr_phase(5'h00, 1'b1, 3'b001);
    @(posedge clk); #1;
    idle_bus();
    check("rst_err1_hreadyout", {31'd0, hreadyout}, 32'h0);
    #1 hreset_n = 1'b0;
    #1;
    check("arst_led", {24'd0, led}, 32'h0);
    check("arst_hresp", {31'd0, hresp}, 32'h0);
    check("arst_hreadyout", {31'd0, hreadyout}, 32'h1);
    @(negedge clk);
    hreset_n = 1'b1;
    @(posedge clk); #1;
    read_word(5'h14, rd);
    check("arst_val", rd, 32'h0);
    read_word(5'h0C, rd);
    check("arst_ctrl", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
